dmem_responder: RTL and testbench

// - Responder end of the datapath data-memory port. It serves en/wen/addr/wdata requests from the multicycle core
//   and returns registered rdata.
// - A byte-serial loader port pre-loads program data into the array. Backed by a single-port word-wide sync RAM.
// - Sub-word stores arrive pre-merged from the core (read-modify-write), so the array sees full-word writes only.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_responder_if.sv | 37 +++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 156 +++++++++++++++
 tb/tb_dmem_responder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

  localparam int unsigned DMEM_ADDR_W = 13;
  localparam int unsigned WORD_BYTES  = 4;

  function automatic logic [DMEM_ADDR_W-3:0] word_idx(input logic [DMEM_ADDR_W-1:0] addr);
    return addr[DMEM_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory port plus byte-serial loader port, bundled for the responder.
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned LEN_W  = 11
) ();

  logic              dmem_en;
  logic              dmem_wen;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;

  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [LEN_W-1:0]  ld_len;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic              oor_err;

  modport master (
    output dmem_en, dmem_wen, dmem_addr, dmem_wdata,
    output ld_start, ld_base, ld_len, ld_valid, ld_byte,
    input  dmem_rdata, ld_ready, ld_busy, ld_done, oor_err
  );

  modport slave (
    input  dmem_en, dmem_wen, dmem_addr, dmem_wdata,
    input  ld_start, ld_base, ld_len, ld_valid, ld_byte,
    output dmem_rdata, ld_ready, ld_busy, ld_done, oor_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word-wide synchronous RAM with registered read data (not reset).
module dmem_array #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_idx] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: core port always wins the array; a byte-serial loader fills
// words in the gaps. Owns the load FSM, out-of-range flag and read-data hold.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned LEN_W  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WORD_W = ADDR_W - 2;

  ld_state_t         r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_asm;
  logic              r_busy;
  logic              r_done;
  logic              r_oor;
  logic              r_rd_zero;

  logic [WORD_W-1:0] w_core_word;
  logic [WORD_W-1:0] w_base_word;
  logic [IDX_W-1:0]  w_base_idx;
  logic [IDX_W-1:0]  w_ptr_next;
  logic              w_core_oor;
  logic              w_core_ok;
  logic              w_ld_ready;
  logic              w_ld_fire;
  logic              w_ld_commit;
  logic [31:0]       w_ld_word;
  logic              w_arr_en;
  logic              w_arr_we;
  logic [IDX_W-1:0]  w_arr_idx;
  logic [31:0]       w_arr_wdata;
  logic [31:0]       w_arr_rdata;
  logic              w_unused_lsbs;

  assign w_core_word   = bus.dmem_addr[ADDR_W-1:2];
  assign w_base_word   = bus.ld_base[ADDR_W-1:2];
  assign w_unused_lsbs = ^{bus.dmem_addr[1:0], bus.ld_base[1:0]};

  assign w_core_oor = 32'(w_core_word) >= DEPTH;
  assign w_core_ok  = bus.dmem_en & ~w_core_oor;
  assign w_base_idx = IDX_W'(32'(w_base_word) % DEPTH);
  assign w_ptr_next = (r_ptr == IDX_W'(DEPTH - 1)) ? '0 : r_ptr + IDX_W'(1);

  // Loader only sees the array port when the core is not asking for it.
  assign w_ld_ready  = (r_state == LD_LOAD) & ~bus.dmem_en;
  assign w_ld_fire   = bus.ld_valid & w_ld_ready;
  assign w_ld_commit = w_ld_fire & (r_byte_cnt == 2'(WORD_BYTES - 1));

  always_comb begin
    w_ld_word = r_asm;
    w_ld_word[{r_byte_cnt, 3'b000} +: 8] = bus.ld_byte;
  end

  assign w_arr_en    = w_core_ok | w_ld_commit;
  assign w_arr_we    = (w_core_ok & bus.dmem_wen) | w_ld_commit;
  assign w_arr_idx   = bus.dmem_en ? w_core_word[IDX_W-1:0] : r_ptr;
  assign w_arr_wdata = bus.dmem_en ? bus.dmem_wdata : w_ld_word;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_en    (w_arr_en),
    .i_we    (w_arr_we),
    .i_idx   (w_arr_idx),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LD_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_byte_cnt  <= '0;
      r_asm       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        LD_IDLE: begin
          r_done <= 1'b0;
          if (bus.ld_start) begin
            r_ptr       <= w_base_idx;
            r_remaining <= bus.ld_len;
            r_byte_cnt  <= '0;
            r_busy      <= 1'b1;
            if (bus.ld_len == '0) begin
              r_state <= LD_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= LD_LOAD;
            end
          end
        end
        LD_LOAD: begin
          if (w_ld_commit) begin
            r_byte_cnt  <= '0;
            r_ptr       <= w_ptr_next;
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_state <= LD_DONE;
              r_done  <= 1'b1;
            end
          end else if (w_ld_fire) begin
            r_asm[{r_byte_cnt, 3'b000} +: 8] <= bus.ld_byte;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        LD_DONE: begin
          r_state <= LD_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= LD_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // The RAM output holds between reads; r_rd_zero masks it after reset and OOR reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oor     <= 1'b0;
      r_rd_zero <= 1'b1;
    end else if (bus.dmem_en) begin
      if (w_core_oor) begin
        r_oor <= 1'b1;
      end
      if (!bus.dmem_wen) begin
        r_rd_zero <= w_core_oor;
      end
    end
  end

  assign bus.dmem_rdata = r_rd_zero ? 32'h0 : w_arr_rdata;
  assign bus.ld_ready   = w_ld_ready;
  assign bus.ld_busy    = r_busy;
  assign bus.ld_done    = r_done;
  assign bus.oor_err    = r_oor;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one stimulus stream drives a 2048-word and a 16-word responder,
// both checked every cycle against a behavioural memory/loader model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, wen, start, valid;
  logic [12:0] addr, base;
  logic [31:0] wdata;
  logic [10:0] len;
  logic [7:0]  lbyte;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(13), .LEN_W(11)) bus0 ();
  dmem_responder_if #(.ADDR_W(13), .LEN_W(11)) bus1 ();

  assign bus0.dmem_en = en;    assign bus1.dmem_en = en;
  assign bus0.dmem_wen = wen;  assign bus1.dmem_wen = wen;
  assign bus0.dmem_addr = addr; assign bus1.dmem_addr = addr;
  assign bus0.dmem_wdata = wdata; assign bus1.dmem_wdata = wdata;
  assign bus0.ld_start = start; assign bus1.ld_start = start;
  assign bus0.ld_base = base;  assign bus1.ld_base = base;
  assign bus0.ld_len = len;    assign bus1.ld_len = len;
  assign bus0.ld_valid = valid; assign bus1.ld_valid = valid;
  assign bus0.ld_byte = lbyte; assign bus1.ld_byte = lbyte;

  dmem_responder #(.ADDR_W(13), .DEPTH(2048), .LEN_W(11)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  dmem_responder #(.ADDR_W(13), .DEPTH(16), .LEN_W(11)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic [31:0] d_rdata [2];
  logic        d_ready [2];
  logic        d_busy  [2];
  logic        d_done  [2];
  logic        d_oor   [2];

  assign d_rdata[0] = bus0.dmem_rdata; assign d_rdata[1] = bus1.dmem_rdata;
  assign d_ready[0] = bus0.ld_ready;   assign d_ready[1] = bus1.ld_ready;
  assign d_busy[0]  = bus0.ld_busy;    assign d_busy[1]  = bus1.ld_busy;
  assign d_done[0]  = bus0.ld_done;    assign d_done[1]  = bus1.ld_done;
  assign d_oor[0]   = bus0.oor_err;    assign d_oor[1]   = bus1.oor_err;

  // Model: 0 idle, 1 loading, 2 done
  logic [31:0] m_mem [int];
  int          m_phase [2];
  int          m_ptr   [2];
  int          m_rem   [2];
  int          m_cnt   [2];
  logic [31:0] m_asm   [2];
  logic        m_oor   [2];
  logic [31:0] m_rd    [2];
  bit          m_rd_known [2];

  function automatic int depth_of(int d);
    return (d == 0) ? 2048 : 16;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_cnt[d] = 0; m_asm[d] = 0;
      m_oor[d] = 1'b0; m_rd[d] = 32'h0; m_rd_known[d] = 1'b1;
    end
  endtask

  task automatic model_step(input int d);
    int dp, idx, key;
    bit ready;
    dp    = depth_of(d);
    idx   = int'(addr) / 4;
    ready = (m_phase[d] == 1) && !en;
    if (en) begin
      if (idx >= dp) begin
        m_oor[d] = 1'b1;
        if (!wen) begin m_rd[d] = 32'h0; m_rd_known[d] = 1'b1; end
      end else begin
        key = d * 65536 + idx;
        if (wen) m_mem[key] = wdata;
        else if (m_mem.exists(key)) begin m_rd[d] = m_mem[key]; m_rd_known[d] = 1'b1; end
        else m_rd_known[d] = 1'b0;
      end
    end
    case (m_phase[d])
      0: if (start) begin
        m_ptr[d] = (int'(base) / 4) % dp;
        m_rem[d] = int'(len);
        m_cnt[d] = 0; m_asm[d] = 0;
        m_phase[d] = (len == 0) ? 2 : 1;
      end
      1: if (valid && ready) begin
        m_asm[d] = m_asm[d] | (32'(lbyte) << (8 * m_cnt[d]));
        m_cnt[d]++;
        if (m_cnt[d] == 4) begin
          m_mem[d * 65536 + m_ptr[d]] = m_asm[d];
          m_ptr[d] = (m_ptr[d] + 1) % dp;
          m_rem[d]--;
          m_cnt[d] = 0; m_asm[d] = 0;
          if (m_rem[d] == 0) m_phase[d] = 2;
        end
      end
      default: m_phase[d] = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (m_rd_known[d]) check($sformatf("dut%0d_rdata", d), d_rdata[d], m_rd[d]);
        check($sformatf("dut%0d_oor_err", d), 32'(d_oor[d]), 32'(m_oor[d]));
        check($sformatf("dut%0d_ld_busy", d), 32'(d_busy[d]), 32'(m_phase[d] != 0));
        check($sformatf("dut%0d_ld_done", d), 32'(d_done[d]), 32'(m_phase[d] == 2));
        check($sformatf("dut%0d_ld_ready", d), 32'(d_ready[d]), 32'((m_phase[d] == 1) && !en));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [12:0] a, input logic [31:0] dat);
    en = 1'b1; wen = 1'b1; addr = a; wdata = dat;
    tick();
    en = 1'b0; wen = 1'b0;
  endtask

  task automatic core_read(input logic [12:0] a);
    en = 1'b1; wen = 1'b0; addr = a;
    tick();
    en = 1'b0;
  endtask

  task automatic ld_begin(input logic [12:0] b, input logic [10:0] l);
    start = 1'b1; base = b; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    valid = 1'b1; lbyte = b;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus0.ld_done && n < 40) begin tick(); n++; end
    check(name, 32'(bus0.ld_done), 32'd1);
    tick();
    check({name, "_after"}, {30'd0, bus0.ld_busy, bus0.ld_done}, 32'd0);
  endtask

  initial begin
    logic [7:0] burst [8];
    rst_n = 1'b0; en = 1'b0; wen = 1'b0; start = 1'b0; valid = 1'b0;
    addr = '0; base = '0; wdata = '0; len = '0; lbyte = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_rdata", bus0.dmem_rdata, 32'h0);
    check("reset_flags", {29'd0, bus0.oor_err, bus0.ld_busy, bus0.ld_done}, 32'd0);

    core_write(13'h0010, 32'hDEADBEEF);
    core_read(13'h0010);
    check("rd_0010", bus0.dmem_rdata, 32'hDEADBEEF);
    repeat (3) tick();
    check("rd_0010_hold", bus0.dmem_rdata, 32'hDEADBEEF);

    core_write(13'h0020, 32'h12345678);
    core_read(13'h0023);
    check("rd_0023_lowbits", bus0.dmem_rdata, 32'h12345678);

    rst_n = 1'b0;
    #2;
    check("async_reset_rdata", bus0.dmem_rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("reset2_flags", {29'd0, bus0.oor_err, bus0.ld_busy, bus0.ld_done}, 32'd0);

    // Burst of two words with one contended byte
    burst = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ld_begin(13'h0100, 11'd2);
    check("busy_in_load", 32'(bus0.ld_busy), 32'd1);
    for (int i = 0; i < 5; i++) send_byte(burst[i]);
    en = 1'b1; wen = 1'b0; addr = 13'h0100; valid = 1'b1; lbyte = burst[5];
    #1;
    check("contention_ready", 32'(bus0.ld_ready), 32'd0);
    tick();
    check("contention_read", bus0.dmem_rdata, 32'h12345678);
    en = 1'b0;
    tick();
    valid = 1'b0;
    send_byte(burst[6]);
    send_byte(burst[7]);
    wait_done("burst_done");
    core_read(13'h0100);
    check("rd_0100", bus0.dmem_rdata, 32'h12345678);
    core_read(13'h0104);
    check("rd_0104", bus0.dmem_rdata, 32'hDEADBEEF);

    // Wrap: small build lands at 15 and 0, large build at 15 and 16
    ld_begin(13'h003C, 11'd2);
    for (int i = 0; i < 8; i++) send_byte(8'h11 * 8'(i + 1));
    wait_done("wrap_done");
    core_read(13'h003C);
    check("wrap_idx15_small", bus1.dmem_rdata, 32'h44332211);
    check("wrap_idx15_large", bus0.dmem_rdata, 32'h44332211);
    core_read(13'h0000);
    check("wrap_idx0_small", bus1.dmem_rdata, 32'h88776655);

    // 0x40 is word 16: out of range only for the small build
    core_read(13'h0040);
    check("oor_rdata_small", bus1.dmem_rdata, 32'h0);
    check("oor_flag_small", 32'(bus1.oor_err), 32'd1);
    check("idx16_large", bus0.dmem_rdata, 32'h88776655);
    repeat (2) tick();
    check("oor_sticky", 32'(bus1.oor_err), 32'd1);

    ld_begin(13'h0000, 11'd0);
    check("zero_len_done", {30'd0, bus0.ld_busy, bus0.ld_done}, 32'd3);
    tick();
    check("zero_len_done_end", {30'd0, bus0.ld_busy, bus0.ld_done}, 32'd0);

    // Reset mid-burst must leave the target word alone and discard the partial bytes
    core_write(13'h0008, 32'hAAAA5555);
    ld_begin(13'h0008, 11'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    rst_n = 1'b0;
    tick();
    check("midload_reset_busy", 32'(bus0.ld_busy), 32'd0);
    check("midload_reset_oor", 32'(bus1.oor_err), 32'd0);
    rst_n = 1'b1;
    tick();
    core_read(13'h0008);
    check("midload_word_kept", bus0.dmem_rdata, 32'hAAAA5555);
    ld_begin(13'h0008, 11'd1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA1 + i));
    wait_done("reload_done");
    core_read(13'h0008);
    check("reload_word", bus0.dmem_rdata, 32'hA4A3A2A1);
    check("reload_word_small", bus1.dmem_rdata, 32'hA4A3A2A1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
